// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative 32-bit multiply/divide unit for the EXE stage.
// Runs MULT/MULTU/DIV/DIVU over 32 iteration cycles and owns the HI/LO pair.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        level request from the instruction currently in EXE
//   op           000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                101 MTHI, 110 MTLO, 111 reserved (none)
//   a, b         rs_value / rt_value operands
//   hold         pipeline stalled by another source this cycle
//   flush        EXE instruction is being killed
//   hi, lo       HI/LO registers (feed MFHI/MFLO)
//   busy, done   state flags (BUSY / DONE)
//   stall        combinational stall for IF/ID/EXE
//   dbg_state    current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: the EXE instruction presents start/op/a/b as a level. A
// muldiv op is taken at the first edge where the unit is IDLE and flush=0;
// stall is raised combinationally in that same cycle and stays up while
// BUSY, so the instruction holds its inputs until the DONE cycle, where
// stall drops and the instruction leaves EXE on the next edge (hold=0).
// start is not looked at in BUSY or DONE. MTHI/MTLO never stall; they
// write on the edge where the unit is IDLE and start=1, hold=0, flush=0.
module exe_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic        is_div_q;
  logic [63:0] acc;        // MUL: running product; DIV: {remainder, quotient/dividend}
  logic [31:0] opnd;       // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic        res_neg;    // negate product / quotient
  logic        rem_neg;    // remainder takes the sign of the dividend
  logic        div_zero;

  // ---------------- request decode ----------------
  logic is_md, is_div_in, signed_in, accept, mt_ok, last_step;
  logic a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    is_md     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_div_in = (op == OP_DIV) || (op == OP_DIVU);
    signed_in = (op == OP_MULT) || (op == OP_DIV);
    accept    = (state == IDLE) && start && is_md && !flush;
    mt_ok     = (state == IDLE) && start && !hold && !flush;
    last_step = (state == BUSY) && !flush && (cnt == 5'd31);
    a_neg     = signed_in && a[31];
    b_neg     = signed_in && b[31];
    a_mag     = a_neg ? (32'd0 - a) : a;
    b_mag     = b_neg ? (32'd0 - b) : b;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = BUSY;
      BUSY: begin
        if (flush)             state_nx = IDLE;
        else if (cnt == 5'd31) state_nx = DONE;
      end
      DONE: if (flush || !hold) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = (state == BUSY);
  assign done      = (state == DONE);
  assign stall     = accept || (state == BUSY);
  assign dbg_state = state;

  // ---------------- one iteration ----------------
  logic [32:0] mul_sum;
  logic [32:0] div_t;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] acc_nx;

  always_comb begin
    // shift-add: add multiplicand into the upper half when the low bit is set,
    // then shift the whole 65-bit value right by one
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    // restoring division: shift the next dividend bit into the remainder
    div_t   = {acc[63:32], acc[31]};
    div_ge  = (div_t >= {1'b0, opnd});
    div_rem = div_ge ? 32'(div_t - {1'b0, opnd}) : div_t[31:0];
    if (is_div_q) acc_nx = {div_rem, acc[30:0], div_ge};
    else          acc_nx = {mul_sum, acc[31:1]};
  end

  // ---------------- sign fix-up of the final iteration ----------------
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    prod_fix = res_neg ? (64'd0 - acc_nx) : acc_nx;
    // a zero divisor yields all-ones quotient regardless of operand signs;
    // the remainder then equals |a| re-signed, i.e. a itself
    if (div_zero)     quot_fix = 32'hFFFF_FFFF;
    else if (res_neg) quot_fix = 32'd0 - acc_nx[31:0];
    else              quot_fix = acc_nx[31:0];
    rem_fix = rem_neg ? (32'd0 - acc_nx[63:32]) : acc_nx[63:32];
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 5'd0;
      is_div_q <= 1'b0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= 5'd0;
      is_div_q <= is_div_in;
      acc      <= {32'd0, (is_div_in ? a_mag : b_mag)};
      opnd     <= is_div_in ? b_mag : a_mag;
      res_neg  <= a_neg ^ b_neg;
      rem_neg  <= a_neg;
      div_zero <= (b == 32'd0);
    end else if ((state == BUSY) && !flush) begin
      cnt <= cnt + 5'd1;
      acc <= acc_nx;
    end
  end

  // ---------------- HI/LO ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (last_step) begin
      if (is_div_q) begin
        hi <= rem_fix;
        lo <= quot_fix;
      end else begin
        hi <= prod_fix[63:32];
        lo <= prod_fix[31:0];
      end
    end else if (mt_ok && (op == OP_MTHI)) begin
      hi <= a;
    end else if (mt_ok && (op == OP_MTLO)) begin
      lo <= a;
    end
  end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative multiply/divide unit in the EXE stage of the 54-instruction pipelined CPU. It takes rs_value and rt_value (the same operands that reach the EXE A/B operand muxes), runs MULT/MULTU/DIV/DIVU over 32 iteration cycles and holds the HI/LO register pair. HI/LO feed the MFHI/MFLO path into the WB data mux. While an operation runs, the block stalls the front of the pipeline.

## Interface
- No parameters; datapath is fixed at 32 bits.

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; the EXE instruction requests a muldiv/MTHI/MTLO operation
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
- a  in  32  rs_value
- b  in  32  rt_value
- hold  in  1  pipeline is stalled by another source; the EXE instruction does not advance this cycle
- flush  in  1  the EXE instruction is being killed
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  registered; high in the BUSY state
- done  out  1  registered; high in the DONE state
- stall  out  1  combinational; holds IF/ID/EXE

## Operation
- States: IDLE, BUSY, DONE. A 5-bit counter cnt is used in BUSY.
- The operation is accepted when state is IDLE, start=1, op is 001–100 and flush=0. On acceptance, a, b and op are latched, cnt is set to 0 and the next state is BUSY.
- BUSY performs one iteration per cycle and increments cnt. On the edge where cnt=31, the result is written to HI/LO and the next state is DONE.
- DONE moves to IDLE when hold=0 and stays in DONE when hold=1. start is ignored in DONE, so the stalled instruction is never restarted.
- stall = (IDLE and start and op in 001–100 and not flush) or BUSY. stall is 0 in DONE.
- MTHI/MTLO are accepted only in IDLE with start=1, hold=0 and flush=0. hi (or lo) takes the value of a at the next edge. There is no stall and no state change.
- MULTU: unsigned shift-add of a×b, 64-bit product, HI = bits [63:32], LO = bits [31:0].
- MULT: multiply the magnitudes, then negate the 64-bit product if sign(a) differs from sign(b).
- DIVU: restoring division, one quotient bit per cycle. LO = quotient, HI = remainder.
- DIV: divide |a| by |b| unsigned. Negate the quotient if the signs differ. The remainder takes the sign of a.
- Divide by zero (DIV or DIVU) runs the full 32 cycles. Result is LO=0xFFFFFFFF, HI=a, independent of signs.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- flush in BUSY or DONE forces IDLE at the next edge. HI/LO are left unchanged, and a result due on that edge is discarded.
- flush has priority over completion and over MTHI/MTLO.
- Reset (any state, mid-operation included) forces IDLE, cnt=0, hi=lo=0, busy=done=0 immediately. stall falls to 0 unless the IDLE acceptance term is true.

## Timing
- Edge E0: operation accepted; stall is already high in the cycle before E0.
- E1..E32: busy=1; HI/LO are written at E32.
- After E32: DONE for 1 cycle (more if hold=1); done=1; stall=0. The instruction leaves EXE at the next edge.
- Stall duration: 33 cycles. EXE residency: 34 cycles when hold=0.
- hi/lo are valid in the DONE cycle. An MFHI/MFLO immediately behind the instruction reads the new value with no forwarding.
- Back-to-back muldiv: the next instruction enters EXE while the unit is IDLE and is accepted at that edge.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 -> after 32 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; stall high for exactly 33 cycles; done high 1 cycle.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then MULT 0x80000000×0x80000000 back-to-back -> HI=0x40000000, LO=0.
- DIV a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678 after the full 32 cycles.
- Flush while cnt=10 during DIVU (prior HI=0xA, LO=0xB) -> IDLE next cycle, HI=0xA, LO=0xB, stall=0. hold=1 in DONE for 3 cycles -> no restart, done stays high, returns to IDLE when hold drops.
- MTHI a=0xCAFEBABE, MTLO a=0x1 -> hi/lo updated after 1 edge, no stall. rst_n low at cnt=20 -> hi=lo=0, busy=0 asynchronously.
